// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// RISC-V load/store funct3 encodings and access-size decode.
`ifndef MEM_DEPTH
`define MEM_DEPTH 4096
`endif

package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Access size in bytes; 0 marks a funct3 that is illegal for the direction.
  function automatic logic [2:0] access_bytes(input logic we, input logic [2:0] funct3);
    logic [2:0] n;
    n = 3'd0;
    if (we) begin
      case (funct3)
        FUNCT3_SB: n = 3'd1;
        FUNCT3_SH: n = 3'd2;
        FUNCT3_SW: n = 3'd4;
        default:   n = 3'd0;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LBU: n = 3'd1;
        FUNCT3_LH, FUNCT3_LHU: n = 3'd2;
        FUNCT3_LW:             n = 3'd4;
        default:               n = 3'd0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the responder: store mask/data placement on the write
// side and lane extraction with sign/zero extension on the read side.
module dmem_lane_align
  import dmem_responder_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int LANE_W = 2
) (
  input  logic [LANE_W-1:0]   wr_lane_i,
  input  logic [2:0]          wr_funct3_i,
  input  logic [DWIDTH-1:0]   wr_data_i,
  output logic [DWIDTH/8-1:0] wr_mask_o,
  output logic [DWIDTH-1:0]   wr_data_o,
  input  logic [LANE_W-1:0]   rd_lane_i,
  input  logic [2:0]          rd_funct3_i,
  input  logic [DWIDTH-1:0]   rd_word_i,
  output logic [DWIDTH-1:0]   rd_data_o
);
  localparam int NLANES = DWIDTH / 8;

  logic [LANE_W+2:0] wr_sh;
  logic [LANE_W+2:0] rd_sh;
  logic [DWIDTH-1:0] rd_shifted;

  assign wr_sh = {wr_lane_i, 3'b000};
  assign rd_sh = {rd_lane_i, 3'b000};

  always_comb begin
    wr_mask_o = '0;
    wr_data_o = '0;
    case (wr_funct3_i)
      FUNCT3_SB: begin
        wr_mask_o = NLANES'(1) << wr_lane_i;
        wr_data_o = DWIDTH'(wr_data_i[7:0]) << wr_sh;
      end
      FUNCT3_SH: begin
        wr_mask_o = NLANES'(3) << wr_lane_i;
        wr_data_o = DWIDTH'(wr_data_i[15:0]) << wr_sh;
      end
      FUNCT3_SW: begin
        wr_mask_o = NLANES'(15) << wr_lane_i;
        wr_data_o = DWIDTH'(wr_data_i[31:0]) << wr_sh;
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend to the full width.
  always_comb begin
    rd_shifted = rd_word_i >> rd_sh;
    rd_data_o  = '0;
    case (rd_funct3_i)
      FUNCT3_LB:  rd_data_o = {{(DWIDTH-8){rd_shifted[7]}}, rd_shifted[7:0]};
      FUNCT3_LBU: rd_data_o = DWIDTH'(rd_shifted[7:0]);
      FUNCT3_LH:  rd_data_o = {{(DWIDTH-16){rd_shifted[15]}}, rd_shifted[15:0]};
      FUNCT3_LHU: rd_data_o = DWIDTH'(rd_shifted[15:0]);
      FUNCT3_LW:  rd_data_o = DWIDTH'(rd_shifted[31:0]);
      default:    rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed accept-to-response latency,
// little-endian byte-lane storage and error reporting for illegal accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter int                DEPTH     = `MEM_DEPTH,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int NLANES = DWIDTH / 8;
  localparam int LANE_W = $clog2(NLANES);
  localparam int WORDS  = DEPTH / NLANES;
  localparam int WIDX_W = $clog2(WORDS);
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              we_q;
  logic [2:0]        f3_q;

  logic              rsp_err_q;
  logic              rsp_we_q;
  logic [2:0]        rsp_f3_q;
  logic [LANE_W-1:0] rsp_lane_q;

  logic              accept;
  logic              enter_resp;
  logic              idle;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_wdata;
  logic              acc_we;
  logic [2:0]        acc_f3;
  logic [AWIDTH-1:0] acc_off;
  logic [AWIDTH:0]   acc_end;
  logic [2:0]        acc_size;
  logic              acc_err;
  logic [WIDX_W-1:0] acc_widx;
  logic              mem_we;

  logic [NLANES-1:0] wr_mask;
  logic [DWIDTH-1:0] wr_data_al;
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] rd_ext;

  // Ready is gated by reset so it reads 0 while reset is held.
  assign idle        = (state_q == IDLE);
  assign req_ready_o = rst & idle;
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_q != RESP) && (state_d == RESP);

  // With LATENCY = 1 the access happens on the accept edge, so the live
  // request inputs are used instead of the captured copies.
  assign acc_addr  = idle ? req_addr_i   : addr_q;
  assign acc_wdata = idle ? req_wdata_i  : wdata_q;
  assign acc_we    = idle ? req_we_i     : we_q;
  assign acc_f3    = idle ? req_funct3_i : f3_q;
  assign acc_off   = acc_addr - BASE_ADDR;
  assign acc_widx  = acc_off[LANE_W +: WIDX_W];

  // End address is formed one bit wider so offsets near 2^AWIDTH cannot wrap.
  always_comb begin
    acc_size = access_bytes(acc_we, acc_f3);
    acc_end  = {1'b0, acc_off} + (AWIDTH+1)'(acc_size);
    acc_err  = (acc_size == 3'd0)
            || ((acc_size == 3'd2) && acc_addr[0])
            || ((acc_size == 3'd4) && (acc_addr[1:0] != 2'b00))
            || (acc_addr < BASE_ADDR)
            || (acc_end > (AWIDTH+1)'(DEPTH));
  end

  assign mem_we = enter_resp & acc_we & ~acc_err;

  dmem_lane_align #(
    .DWIDTH (DWIDTH),
    .LANE_W (LANE_W)
  ) u_align (
    .wr_lane_i   (acc_off[LANE_W-1:0]),
    .wr_funct3_i (acc_f3),
    .wr_data_i   (acc_wdata),
    .wr_mask_o   (wr_mask),
    .wr_data_o   (wr_data_al),
    .rd_lane_i   (rsp_lane_q),
    .rd_funct3_i (rsp_f3_q),
    .rd_word_i   (rd_word),
    .rd_data_o   (rd_ext)
  );

  // One byte-wide RAM per lane; contents survive reset.
  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      logic [7:0] mem_q [WORDS];
      logic [7:0] rd_byte_q;
      always_ff @(posedge clk) begin
        if (mem_we && wr_mask[gi]) mem_q[acc_widx] <= wr_data_al[gi*8 +: 8];
        if (enter_resp)            rd_byte_q       <= mem_q[acc_widx];
      end
      assign rd_word[gi*8 +: 8] = rd_byte_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      rsp_err_q  <= 1'b0;
      rsp_we_q   <= 1'b0;
      rsp_f3_q   <= '0;
      rsp_lane_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
      end
      if (enter_resp) begin
        rsp_err_q  <= acc_err;
        rsp_we_q   <= acc_we;
        rsp_f3_q   <= acc_f3;
        rsp_lane_q <= acc_off[LANE_W-1:0];
      end
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o & rsp_err_q;
  assign rsp_rdata_o = (rsp_valid_o && !rsp_err_q && !rsp_we_q) ? rd_ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY = 2, BASE_ADDR = 0x01000000, 4 KiB).
module tb_dmem_responder;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [2:0] F_SB  = 3'b000;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;
  localparam logic [2:0] F_BAD = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .AWIDTH    (32),
    .DWIDTH    (32),
    .BASE_ADDR (32'h0100_0000),
    .DEPTH     (4096),
    .LATENCY   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
  endtask

  // Full transaction: accept, measure latency, check response, handshake, check idle.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    drive_req(we, f3, addr, wdata);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid_o === 1'b1) break;
    end
    check({tag, "_lat"},   32'(lat),                 32'd2);
    check({tag, "_rdata"}, rsp_rdata_o,              exp_rd);
    check({tag, "_err"},   {31'b0, rsp_err_o},       {31'b0, exp_err});
    $display("txn %s we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             tag, we, f3, addr, wdata, rsp_rdata_o, rsp_err_o, lat);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk);
    check({tag, "_post_valid"}, {31'b0, rsp_valid_o}, 32'd0);
    check({tag, "_post_ready"}, {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b000;
    req_addr_i   = 32'h0;
    req_wdata_i  = 32'h0;
    rsp_ready_i  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready_o}, 32'd0);
    check("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o,          32'd0);
    check("rst_err",   {31'b0, rsp_err_o},   32'd0);
    rst = 1'b1;
    #1 check("rst_release_ready", {31'b0, req_ready_o}, 32'd1);

    txn("sw_dead",   1'b1, F_SW,  32'h0100_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    txn("lw_dead",   1'b0, F_LW,  32'h0100_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    txn("lb_13",     1'b0, F_LB,  32'h0100_0013, 32'h0,         32'hFFFF_FFDE, 1'b0);
    txn("lbu_13",    1'b0, F_LBU, 32'h0100_0013, 32'h0,         32'h0000_00DE, 1'b0);
    txn("lh_12",     1'b0, F_LH,  32'h0100_0012, 32'h0,         32'hFFFF_DEAD, 1'b0);
    txn("lhu_12",    1'b0, F_LHU, 32'h0100_0012, 32'h0,         32'h0000_DEAD, 1'b0);
    txn("sh_mis",    1'b1, F_SH,  32'h0100_0011, 32'h0000_FFFF, 32'h0000_0000, 1'b1);
    txn("lw_after",  1'b0, F_LW,  32'h0100_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    txn("lw_below",  1'b0, F_LW,  32'h00FF_FFFC, 32'h0,         32'h0000_0000, 1'b1);
    txn("sb_11",     1'b1, F_SB,  32'h0100_0011, 32'hAAAA_AA55, 32'h0000_0000, 1'b0);
    txn("lw_sb",     1'b0, F_LW,  32'h0100_0010, 32'h0,         32'hDEAD_55EF, 1'b0);
    txn("lw_mis",    1'b0, F_LW,  32'h0100_0012, 32'h0,         32'h0000_0000, 1'b1);
    txn("ld_badf3",  1'b0, F_BAD, 32'h0100_0010, 32'h0,         32'h0000_0000, 1'b1);
    txn("st_badf3",  1'b1, F_BAD, 32'h0100_0010, 32'h0,         32'h0000_0000, 1'b1);
    txn("sw_top",    1'b1, F_SW,  32'h0100_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0);
    txn("lw_top",    1'b0, F_LW,  32'h0100_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0);
    txn("lh_top",    1'b0, F_LH,  32'h0100_0FFE, 32'h0,         32'hFFFF_CAFE, 1'b0);
    txn("lhu_top",   1'b0, F_LHU, 32'h0100_0FFE, 32'h0,         32'h0000_CAFE, 1'b0);
    txn("lbu_ffd",   1'b0, F_LBU, 32'h0100_0FFD, 32'h0,         32'h0000_00F0, 1'b0);
    txn("lb_fff",    1'b0, F_LB,  32'h0100_0FFF, 32'h0,         32'hFFFF_FFCA, 1'b0);
    txn("lw_past",   1'b0, F_LW,  32'h0100_1000, 32'h0,         32'h0000_0000, 1'b1);
    txn("lb_past",   1'b0, F_LB,  32'h0100_1000, 32'h0,         32'h0000_0000, 1'b1);
    txn("lw_wrap",   1'b0, F_LW,  32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1);
    txn("sw_wrap",   1'b1, F_SW,  32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_0000, 1'b1);
    txn("lw_top2",   1'b0, F_LW,  32'h0100_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0);

    // Stall in RESP with a competing store held on the request port.
    @(negedge clk);
    drive_req(1'b0, F_LW, 32'h0100_0010, 32'h0);
    @(posedge clk);
    #1 drive_req(1'b1, F_SW, 32'h0100_0010, 32'h0000_0000);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, rsp_valid_o}, 32'd1);
      check("stall_rdata", rsp_rdata_o,          32'hDEAD_55EF);
      check("stall_err",   {31'b0, rsp_err_o},   32'd0);
      check("stall_ready", {31'b0, req_ready_o}, 32'd0);
      @(negedge clk);
    end
    $display("txn stall lw addr=01000010 rdata=%h err=%0d", rsp_rdata_o, rsp_err_o);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk);
    check("stall_post_ready", {31'b0, req_ready_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("stall_no_extra", {31'b0, rsp_valid_o}, 32'd0);
    txn("lw_unstalled", 1'b0, F_LW, 32'h0100_0010, 32'h0, 32'hDEAD_55EF, 1'b0);

    // Reset while waiting abandons the store.
    txn("sw_111", 1'b1, F_SW, 32'h0100_0020, 32'h1111_1111, 32'h0000_0000, 1'b0);
    @(negedge clk);
    drive_req(1'b1, F_SW, 32'h0100_0020, 32'h1234_5678);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rstwait_ready", {31'b0, req_ready_o}, 32'd0);
    check("rstwait_valid", {31'b0, rsp_valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstwait_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    end
    $display("txn rstwait sw addr=01000020 wdata=12345678 abandoned");
    txn("lw_rstwait", 1'b0, F_LW, 32'h0100_0020, 32'h0, 32'h1111_1111, 1'b0);

    // Reset while responding drops the response.
    @(negedge clk);
    drive_req(1'b0, F_LW, 32'h0100_0020, 32'h0);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rstresp_valid_before", {31'b0, rsp_valid_o}, 32'd1);
    check("rstresp_rdata_before", rsp_rdata_o,          32'h1111_1111);
    rst = 1'b0;
    #1;
    check("rstresp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rstresp_rdata", rsp_rdata_o,          32'd0);
    check("rstresp_err",   {31'b0, rsp_err_o},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rstresp_ready", {31'b0, req_ready_o}, 32'd1);
    @(negedge clk);
    check("rstresp_dropped", {31'b0, rsp_valid_o}, 32'd0);
    $display("txn rstresp lw addr=01000020 dropped");
    txn("lw_final", 1'b0, F_LW, 32'h0100_0020, 32'h0, 32'h1111_1111, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
